// File: rtl/nibble_addsub_seq.sv
// 16-bit add/subtract computed over four cycles through one shared
// nibble-wide adder; result flags are registered at completion.
module nibble_addsub_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] Sum,
    output logic        Ovfl,
    output logic        Zero,
    output logic        Neg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        carry_q, carry_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        sub_q, sub_d;
    logic [15:0] part_q, part_d;
    logic [15:0] sum_q, sum_d;
    logic        ovfl_q, ovfl_d;
    logic        zero_q, zero_d;
    logic        neg_q, neg_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [3:0]  bx_nib;
    logic [3:0]  low;
    logic        c_msb;
    logic [3:0]  nib_sum;
    logic        nib_cout;
    logic [15:0] result;

    // Shared nibble adder: operand select, optional inversion, carry chain
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        unique case (idx_q)
            2'd0: begin a_nib = a_q[3:0];   b_nib = b_q[3:0];   end
            2'd1: begin a_nib = a_q[7:4];   b_nib = b_q[7:4];   end
            2'd2: begin a_nib = a_q[11:8];  b_nib = b_q[11:8];  end
            2'd3: begin a_nib = a_q[15:12]; b_nib = b_q[15:12]; end
            default: begin a_nib = 4'h0; b_nib = 4'h0; end
        endcase
        bx_nib   = sub_q ? ~b_nib : b_nib;
        low      = {1'b0, a_nib[2:0]} + {1'b0, bx_nib[2:0]}
                 + {3'b000, carry_q};
        c_msb    = low[3];
        nib_sum  = {a_nib[3] ^ bx_nib[3] ^ c_msb, low[2:0]};
        nib_cout = (a_nib[3] & bx_nib[3])
                 | (c_msb & (a_nib[3] ^ bx_nib[3]));
        result   = {nib_sum, part_q[11:0]};
    end

    // Next-state and next-output computation for the whole controller
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        part_d  = part_q;
        sum_d   = sum_q;
        ovfl_d  = ovfl_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sub_d   = sub;
                    idx_d   = 2'd0;
                    carry_d = sub;
                    state_d = CALC;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                part_d[{idx_q, 2'b00} +: 4] = nib_sum;
                carry_d = nib_cout;
                if (idx_q == 2'd3) begin
                    sum_d   = result;
                    ovfl_d  = c_msb ^ nib_cout;
                    zero_d  = (result == 16'h0000);
                    neg_d   = result[15];
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous clear of all state and results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            sub_q   <= 1'b0;
            part_q  <= 16'h0000;
            sum_q   <= 16'h0000;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            ovfl_q  <= ovfl_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Sum  = sum_q;
    assign Ovfl = ovfl_q;
    assign Zero = zero_q;
    assign Neg  = neg_q;

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// Directed bench for nibble_addsub_seq with a result scoreboard.
module tb_nibble_addsub_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Sum;
    logic        Ovfl;
    logic        Zero;
    logic        Neg;

    typedef struct {
        logic [15:0] sum;
        logic        ovfl;
        logic        zero;
        logic        neg;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk;
    int   n_fail;

    nibble_addsub_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .Sum  (Sum),
        .Ovfl (Ovfl),
        .Zero (Zero),
        .Neg  (Neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(logic [15:0] a, logic [15:0] b,
                                   logic s);
        exp_t        e;
        logic [15:0] bb;
        logic [16:0] r;
        bb     = s ? ~b : b;
        r      = {1'b0, a} + {1'b0, bb} + {16'h0000, s};
        e.sum  = r[15:0];
        e.ovfl = (a[15] == bb[15]) && (e.sum[15] != a[15]);
        e.zero = (e.sum == 16'h0000);
        e.neg  = e.sum[15];
        return e;
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives start for one edge and queues result.
    task automatic issue(logic [15:0] a, logic [15:0] b, logic s);
        A     = a;
        B     = b;
        sub   = s;
        start = 1'b1;
        exp_q.push_back(model(a, b, s));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done, checks latency/busy count, pops and compares.
    task automatic wait_done(string tag, int lat0, bit scramble);
        int   lat;
        int   nb;
        exp_t e;
        lat = lat0;
        nb  = lat0 - 1;
        while (!done && lat < 20) begin
            if (busy) nb++;
            if (scramble) begin
                A   = 16'($urandom);
                B   = 16'($urandom);
                sub = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, ".done"}, 16'(done), 16'd1);
        chk({tag, ".lat"}, 16'(lat), 16'd5);
        chk({tag, ".busy_cyc"}, 16'(nb), 16'd4);
        chk({tag, ".busy_low"}, 16'(busy), 16'd0);
        if (exp_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 16'd0, 16'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".sum"}, Sum, e.sum);
            chk({tag, ".ovfl"}, 16'(Ovfl), 16'(e.ovfl));
            chk({tag, ".zero"}, 16'(Zero), 16'(e.zero));
            chk({tag, ".neg"}, 16'(Neg), 16'(e.neg));
        end
    endtask

    task automatic run(string tag, logic [15:0] a, logic [15:0] b,
                       logic s);
        issue(a, b, s);
        wait_done(tag, 1, 1'b0);
        @(negedge clk);
        chk({tag, ".single"}, 16'(done), 16'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start  = 1'b0;
        sub    = 1'b0;
        A      = 16'h0000;
        B      = 16'h0000;
        @(negedge clk);
        chk("rst.busy", 16'(busy), 16'd0);
        chk("rst.done", 16'(done), 16'd0);
        chk("rst.sum", Sum, 16'h0000);
        chk("rst.flags", {13'd0, Ovfl, Zero, Neg}, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.busy", 16'(busy), 16'd0);

        run("add", 16'h1234, 16'h4321, 1'b0);
        chk("add.sum_const", Sum, 16'h5555);
        run("wrap", 16'hFFFF, 16'h0001, 1'b0);
        chk("wrap.zero_const", 16'(Zero), 16'd1);
        run("ovf_add", 16'h7FFF, 16'h0001, 1'b0);
        chk("ovf_add.const", {13'd0, Ovfl, Zero, Neg}, 16'b101);
        run("sub_eq", 16'h0005, 16'h0005, 1'b1);
        chk("sub_eq.const", {Sum[12:0], Ovfl, Zero, Neg}, 16'b010);
        run("ovf_sub", 16'h8000, 16'h0001, 1'b1);
        chk("ovf_sub.sum_const", Sum, 16'h7FFF);

        // hold check: idle cycles keep the last result
        repeat (3) @(negedge clk);
        chk("hold.sum", Sum, 16'h7FFF);
        chk("hold.ovfl", 16'(Ovfl), 16'd1);

        // start pulsed during CALC is ignored
        issue(16'h0001, 16'h0002, 1'b0);
        A     = 16'h00FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign.sum_hold", Sum, 16'h7FFF);
        wait_done("ign", 2, 1'b0);
        chk("ign.sum_const", Sum, 16'h0003);

        // back-to-back start in the DONE cycle
        issue(16'h0010, 16'h0020, 1'b0);
        chk("b2b.busy", 16'(busy), 16'd1);
        chk("b2b.done", 16'(done), 16'd0);
        wait_done("b2b", 1, 1'b0);
        chk("b2b.sum_const", Sum, 16'h0030);
        repeat (6) begin
            @(negedge clk);
            chk("noq.busy", 16'(busy), 16'd0);
            chk("noq.done", 16'(done), 16'd0);
        end

        // asynchronous reset in the second CALC cycle
        issue(16'h1111, 16'h1111, 1'b0);
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("mid.busy_pre", 16'(busy), 16'd1);
        rst = 1'b1;
        #1;
        chk("mid.busy", 16'(busy), 16'd0);
        chk("mid.sum", Sum, 16'h0000);
        chk("mid.done", 16'(done), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("mid.nodone", 16'(done), 16'd0);
        end
        run("post_rst", 16'h0002, 16'h0003, 1'b1);
        chk("post_rst.const", {Sum[12:0], Ovfl, Zero, Neg}, 16'hFFF9);

        // operands scrambled during CALC
        issue(16'h1234, 16'h0F0F, 1'b1);
        wait_done("stab1", 1, 1'b1);
        issue(16'h9ABC, 16'hCDEF, 1'b0);
        wait_done("stab2", 1, 1'b1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run("rand", 16'($urandom), 16'($urandom), 1'($urandom));
        end

        chk("sb.empty", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
